// File: rtl/fault_recovery_ctrl.sv
// Per-sensor debounce/recovery sequencer for three fusion sensors; drives enable mask,
// fusion mode and error code. Optional sticky fault log enabled by defining FAULT_LOG_EN.
module fault_recovery_ctrl #(
  parameter int unsigned FAIL_THRESH    = 4,
  parameter int unsigned RECOVER_THRESH = 8,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_valid,
  input  logic [2:0] chk_err,
  input  logic [2:0] rng_err,
  input  logic [2:0] loss_err,
  input  logic       fault_clr,
  input  logic       log_clr,
  output logic [2:0] sensor_en,
  output logic [1:0] fused_mode,
  output logic [3:0] error_code,
  output logic [8:0] fault_log
);

  localparam int unsigned NUM_SENSORS = 3;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  state_e           state_q [NUM_SENSORS];
  state_e           state_d [NUM_SENSORS];
  logic [CNT_W-1:0] cnt_q   [NUM_SENSORS];
  logic [CNT_W-1:0] cnt_d   [NUM_SENSORS];
  logic [CNT_W-1:0] cnt_inc [NUM_SENSORS];

  logic [2:0] fault;
  logic [2:0] sensor_en_q, sensor_en_d;
  logic [1:0] fused_mode_q, fused_mode_d;
  logic [3:0] error_code_q, error_code_d;
  logic       chk_seen_d;
  logic [1:0] en_count;

  assign fault = chk_err | rng_err | loss_err;

  // Next-state for all sensor FSMs plus the derived output values.
  always_comb begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      if (fault_clr) begin
        state_d[i] = ST_OK;
        cnt_d[i]   = '0;
      end else if (frame_valid) begin
        unique case (state_q[i])
          ST_OK: begin
            state_d[i] = fault[i] ? ST_SUSPECT : ST_OK;
            cnt_d[i]   = fault[i] ? CNT_W'(1) : '0;
          end
          ST_SUSPECT: begin
            if (!fault[i]) begin
              state_d[i] = ST_OK;
              cnt_d[i]   = '0;
            end else if (cnt_inc[i] == CNT_W'(FAIL_THRESH)) begin
              state_d[i] = ST_FAILED;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_inc[i];
            end
          end
          ST_FAILED: begin
            state_d[i] = fault[i] ? ST_FAILED : ST_RECOVER;
            cnt_d[i]   = fault[i] ? '0 : CNT_W'(1);
          end
          ST_RECOVER: begin
            if (fault[i]) begin
              state_d[i] = ST_FAILED;
              cnt_d[i]   = '0;
            end else if (cnt_inc[i] == CNT_W'(RECOVER_THRESH)) begin
              state_d[i] = ST_OK;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_inc[i];
            end
          end
          default: begin
            state_d[i] = ST_FAILED;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end

    for (int i = 0; i < NUM_SENSORS; i++) begin
      sensor_en_d[i] = (state_d[i] == ST_OK) || (state_d[i] == ST_SUSPECT);
    end

    en_count     = 2'(sensor_en_d[0]) + 2'(sensor_en_d[1]) + 2'(sensor_en_d[2]);
    fused_mode_d = 2'd3 - en_count;

    chk_seen_d = error_code_q[0];
    if (fault_clr) begin
      chk_seen_d = 1'b0;
    end else if (frame_valid) begin
      chk_seen_d = |chk_err;
    end

    error_code_d = {fused_mode_d == 2'd3, fused_mode_d != 2'd0, ~&sensor_en_d, chk_seen_d};
  end

  // Sensors start untrusted and must prove a clean run before fusion uses them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        state_q[i] <= ST_FAILED;
        cnt_q[i]   <= '0;
      end
      sensor_en_q  <= 3'b000;
      fused_mode_q <= 2'd3;
      error_code_q <= 4'b1110;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sensor_en_q  <= sensor_en_d;
      fused_mode_q <= fused_mode_d;
      error_code_q <= error_code_d;
    end
  end

  assign sensor_en  = sensor_en_q;
  assign fused_mode = fused_mode_q;
  assign error_code = error_code_q;

`ifdef FAULT_LOG_EN
  logic [8:0] fault_log_q, fault_log_d;
  logic       frame_accept;

  // A frame discarded by fault_clr is not logged either.
  assign frame_accept = frame_valid & ~fault_clr;

  always_comb begin
    fault_log_d = fault_log_q;
    if (frame_accept) begin
      fault_log_d = (log_clr ? 9'd0 : fault_log_q) | {loss_err, rng_err, chk_err};
    end else if (log_clr) begin
      fault_log_d = 9'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_log_q <= 9'd0;
    end else begin
      fault_log_q <= fault_log_d;
    end
  end

  assign fault_log = fault_log_q;
`else
  logic unused_log_clr;
  assign unused_log_clr = log_clr;
  assign fault_log      = 9'd0;
`endif

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Randomized self-checking bench for fault_recovery_ctrl against a run-length health model.
module tb_fault_recovery_ctrl;

  localparam int unsigned FAIL_THRESH    = 4;
  localparam int unsigned RECOVER_THRESH = 8;

  logic       clk;
  logic       rst_n;
  logic       frame_valid;
  logic [2:0] chk_err, rng_err, loss_err;
  logic       fault_clr, log_clr;
  logic [2:0] sensor_en;
  logic [1:0] fused_mode;
  logic [3:0] error_code;
  logic [8:0] fault_log;

  int errors = 0;
  int checks = 0;

  // Reference model: a sensor is trusted or not, plus its current fault/clean run length.
  bit         trusted   [3];
  int         fault_run [3];
  int         clean_run [3];
  bit         chk_hold;
  logic [8:0] log_m;

  fault_recovery_ctrl #(
    .FAIL_THRESH   (FAIL_THRESH),
    .RECOVER_THRESH(RECOVER_THRESH),
    .CNT_W         (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_valid(frame_valid),
    .chk_err    (chk_err),
    .rng_err    (rng_err),
    .loss_err   (loss_err),
    .fault_clr  (fault_clr),
    .log_clr    (log_clr),
    .sensor_en  (sensor_en),
    .fused_mode (fused_mode),
    .error_code (error_code),
    .fault_log  (fault_log)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      trusted[i]   = 1'b0;
      fault_run[i] = 0;
      clean_run[i] = 0;
    end
    chk_hold = 1'b0;
    log_m    = 9'd0;
  endtask

  task automatic model_step(input bit fv, input logic [2:0] c, input logic [2:0] r,
                            input logic [2:0] l, input bit fclr, input bit lclr);
    if (fclr) begin
      for (int i = 0; i < 3; i++) begin
        trusted[i]   = 1'b1;
        fault_run[i] = 0;
        clean_run[i] = 0;
      end
      chk_hold = 1'b0;
    end else if (fv) begin
      for (int i = 0; i < 3; i++) begin
        bit f;
        f = c[i] | r[i] | l[i];
        if (trusted[i]) begin
          fault_run[i] = f ? fault_run[i] + 1 : 0;
          if (fault_run[i] >= FAIL_THRESH) begin
            trusted[i]   = 1'b0;
            fault_run[i] = 0;
            clean_run[i] = 0;
          end
        end else begin
          clean_run[i] = f ? 0 : clean_run[i] + 1;
          if (clean_run[i] >= RECOVER_THRESH) begin
            trusted[i]   = 1'b1;
            clean_run[i] = 0;
            fault_run[i] = 0;
          end
        end
      end
      chk_hold = (c != 3'b000);
    end
`ifdef FAULT_LOG_EN
    if (fv && !fclr) log_m = (lclr ? 9'd0 : log_m) | {l, r, c};
    else if (lclr)   log_m = 9'd0;
`endif
  endtask

  task automatic check_all();
    logic [2:0] en;
    int         n;
    logic [1:0] mode;
    en   = {trusted[2], trusted[1], trusted[0]};
    n    = int'(trusted[0]) + int'(trusted[1]) + int'(trusted[2]);
    mode = 2'(3 - n);
    check_val("sensor_en", 32'(sensor_en), 32'(en));
    check_val("fused_mode", 32'(fused_mode), 32'(mode));
    check_val("error_code", 32'(error_code),
              32'({mode == 2'd3, mode != 2'd0, n != 3, chk_hold}));
    check_val("fault_log", 32'(fault_log), 32'(log_m));
  endtask

  // Apply one cycle of inputs, advance model and DUT together, then compare.
  task automatic step(input bit fv, input logic [2:0] c, input logic [2:0] r,
                      input logic [2:0] l, input bit fclr, input bit lclr);
    frame_valid = fv;
    chk_err     = c;
    rng_err     = r;
    loss_err    = l;
    fault_clr   = fclr;
    log_clr     = lclr;
    @(posedge clk);
    model_step(fv, c, r, l, fclr, lclr);
    #1;
    check_all();
    frame_valid = 1'b0;
    fault_clr   = 1'b0;
    log_clr     = 1'b0;
  endtask

  task automatic clean_frames(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] c, r, l;
    int         rate;
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    chk_err     = '0;
    rng_err     = '0;
    loss_err    = '0;
    fault_clr   = 1'b0;
    log_clr     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_en", 32'(sensor_en), 32'h0);
    check_val("reset_mode", 32'(fused_mode), 32'h3);
    check_val("reset_code", 32'(error_code), 32'he);
    check_val("reset_log", 32'(fault_log), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery from reset takes exactly RECOVER_THRESH clean frames.
    clean_frames(7);
    check_val("rec7_en", 32'(sensor_en), 32'h0);
    step(1'b0, 3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    check_val("idle_hold_en", 32'(sensor_en), 32'h0);
    clean_frames(1);
    check_val("rec8_en", 32'(sensor_en), 32'h7);
    check_val("rec8_code", 32'(error_code), 32'h0);

    // Sensor 1 fails on the 4th consecutive loss frame.
    for (int k = 0; k < 3; k++) step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    check_val("susp3_en", 32'(sensor_en), 32'h7);
    step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    check_val("fail_en", 32'(sensor_en), 32'h6);
    check_val("fail_mode", 32'(fused_mode), 32'h1);
    check_val("fail_code", 32'(error_code), 32'h6);

    // A clean frame restarts the suspect count.
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    clean_frames(1);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    check_val("restart_en0", 32'(sensor_en[0]), 32'h1);

    // A fault during recovery restarts the full clean run.
    clean_frames(1);
    for (int k = 0; k < 4; k++) step(1'b1, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0);
    check_val("s2_failed", 32'(sensor_en), 32'h5);
    clean_frames(5);
    step(1'b1, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0);
    clean_frames(7);
    check_val("s2_still_off", 32'(sensor_en[1]), 32'h0);
    clean_frames(1);
    check_val("s2_back", 32'(sensor_en[1]), 32'h1);

    // Operator override beats a same-cycle faulty frame.
    step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0);
    check_val("fclr_en", 32'(sensor_en), 32'h7);
    check_val("fclr_code", 32'(error_code), 32'h0);

    // Sticky log accumulation and clear-with-frame.
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
    step(1'b1, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0);
`ifdef FAULT_LOG_EN
    check_val("log_a", 32'(fault_log), 32'h004);
`else
    check_val("log_a", 32'(fault_log), 32'h000);
`endif
    step(1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
`ifdef FAULT_LOG_EN
    check_val("log_b", 32'(fault_log), 32'h044);
`else
    check_val("log_b", 32'(fault_log), 32'h000);
`endif
    step(1'b1, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1);
`ifdef FAULT_LOG_EN
    check_val("log_c", 32'(fault_log), 32'h010);
`else
    check_val("log_c", 32'(fault_log), 32'h000);
`endif

    // Randomized traffic with alternating fault density and one mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      rate = ((n / 250) % 2 == 0) ? 20 : 4;
      for (int b = 0; b < 3; b++) begin
        c[b] = ($urandom_range(0, rate - 1) == 0);
        r[b] = ($urandom_range(0, rate - 1) == 0);
        l[b] = ($urandom_range(0, rate - 1) == 0);
      end
      if (n == 1700) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, c, r, l,
           $urandom_range(0, 149) == 0, $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
